// File: rtl/tcam_table_loader.sv
// tcam_table_loader: assembles TCAM key/mask entries from narrow beats and commits them atomically.
module tcam_table_loader #(
  parameter int ADDR_WIDTH = 3,
  parameter int KEY_WIDTH  = 144,
  parameter int TCAM_SUM   = 8,
  parameter int BUS_WIDTH  = 48
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [1:0]                            cmd_op,
  input  logic [ADDR_WIDTH-1:0]                 cmd_addr,
  input  logic [ADDR_WIDTH-1:0]                 cmd_num,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [BUS_WIDTH-1:0]                  wr_data,
  output logic [KEY_WIDTH*2*TCAM_SUM:0]         line_message,
  output logic [ADDR_WIDTH-1:0]                 valid_num,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);
  localparam int EW = 2*KEY_WIDTH;
  localparam int BEATS = EW/BUS_WIDTH;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TCAM_SUM-1);
  localparam logic [CW-1:0] CLAST = CW'(BEATS-1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, CLEAR} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] entry_q [TCAM_SUM];
  logic [EW-1:0] entry_d [TCAM_SUM];
  logic [EW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, idx_q, idx_d, valid_num_q, valid_num_d;
  logic done_q, done_d, err_q, err_d;
  logic cmd_fire, wr_fire;
  assign cmd_fire = cmd_valid & cmd_ready;
  assign wr_fire = wr_valid & wr_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      entry_q     <= '{default: '0};
      shadow_q    <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      valid_num_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      valid_num_q <= valid_num_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  // done/err are registered so they land in the cycle after the deciding event (COMMIT for writes)
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    valid_num_d = valid_num_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (cmd_fire) begin
        case (cmd_op)
          2'b00: begin
            state_d = LOAD;
            addr_d  = cmd_addr;
            cnt_d   = '0;
          end
          2'b01: begin
            valid_num_d = cmd_num > LAST ? LAST : cmd_num;
            done_d      = 1'b1;
          end
          2'b10: begin
            state_d     = CLEAR;
            idx_d       = '0;
            valid_num_d = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      LOAD: if (wr_fire) begin
        shadow_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = wr_data;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLAST) begin
          state_d = COMMIT;
          done_d  = addr_q < LAST;
          err_d   = !(addr_q < LAST);
        end
      end
      COMMIT: begin
        if (addr_q < LAST) entry_d[addr_q] = shadow_q;
        state_d = IDLE;
      end
      default: begin
        entry_d[idx_q] = '0;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end
  always_comb begin
    cmd_ready = state_q == IDLE;
    wr_ready  = state_q == LOAD;
    busy      = state_q != IDLE;
  end
  assign valid_num = valid_num_q;
  assign done = done_q;
  assign err = err_q;
  assign line_message[KEY_WIDTH*2*TCAM_SUM] = 1'b1;
  for (genvar i = 0; i < TCAM_SUM; i++) begin : g_line
    assign line_message[i*EW +: EW] = entry_q[i];
  end
endmodule

// File: doc/tcam_table_loader.md
Name: tcam_table_loader

Overview:
- Write side of the parser TCAM: programs the 8-entry key/mask table and the active-entry count consumed by the combinational TCAM lookup block.
- Accepts table-management commands plus narrow data beats, assembles each entry in a shadow register and commits it atomically. The lookup therefore never sees a partially written entry.
- Drives the flat line_message bus and valid_num directly into the lookup block.

Parameters:
- ADDR_WIDTH, 3: entry index width; also the width of valid_num.
- KEY_WIDTH, 144: key width; each entry is 2*KEY_WIDTH bits, with the mask in the upper half and the key in the lower half.
- TCAM_SUM, 8: number of entries; index TCAM_SUM-1 is the miss/default index.
- BUS_WIDTH, 48: data beat width; must divide 2*KEY_WIDTH. BEATS = 2*KEY_WIDTH/BUS_WIDTH (6 by default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 = WRITE entry, 01 = SET_NUM, 10 = CLEAR all, 11 = reserved.
- cmd_addr  in  ADDR_WIDTH  entry index for WRITE.
- cmd_num  in  ADDR_WIDTH  new valid_num for SET_NUM.
- wr_valid  in  1  data beat present.
- wr_ready  out  1  beat accepted when wr_valid & wr_ready.
- wr_data  in  BUS_WIDTH  entry beat; beat 0 carries entry bits [BUS_WIDTH-1:0], ascending.
- line_message  out  KEY_WIDTH*2*TCAM_SUM+1  flat table; entry i occupies bits [i*2*KEY_WIDTH +: 2*KEY_WIDTH]; the top bit is constant 1.
- valid_num  out  ADDR_WIDTH  number of active entries.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse on a rejected or reserved command.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - All entries cleared to key = 0, mask = 0.
  - valid_num = 0; state = IDLE; beat counter = 0.
  - cmd_ready = 1, wr_ready = 0, busy = 0, done = 0, err = 0.
  - line_message top bit = 1 at all times.
  - rst mid-LOAD discards the shadow register; the committed table is still cleared.
- Handshakes:
  - A transfer occurs only on valid & ready at a clk edge.
  - cmd_ready = 1 only in IDLE; wr_ready = 1 only in LOAD.
  - Beats presented outside LOAD are not consumed.
- IDLE, on command accept:
  - WRITE -> LOAD; latch cmd_addr; beat counter = 0.
  - SET_NUM -> IDLE. Next cycle valid_num = min(cmd_num, TCAM_SUM-1). done pulses the following cycle.
  - CLEAR -> CLEAR state; sweep index = 0.
  - Reserved op -> IDLE; err pulses the next cycle; no state change.
- LOAD:
  - Each accepted beat is written into shadow[cnt*BUS_WIDTH +: BUS_WIDTH]; cnt increments.
  - On the beat where cnt == BEATS-1 -> COMMIT.
  - wr_valid low holds the state indefinitely, with no timeout.
- COMMIT (1 cycle):
  - If the latched addr < TCAM_SUM-1, entry[addr] = shadow, which is visible on line_message the next cycle; done pulses.
  - If addr == TCAM_SUM-1 (reserved default index), the table is unchanged and err pulses. The beats were still fully drained.
  - Then -> IDLE.
- CLEAR:
  - One entry per cycle: entry[idx] = 0 for idx = 0..TCAM_SUM-1, taking TCAM_SUM cycles.
  - valid_num = 0 in the first CLEAR cycle, so the lookup ignores stale entries at once.
  - After idx = TCAM_SUM-1: done pulses, -> IDLE.
- Latency:
  - WRITE: cmd accept, then BEATS beat cycles (min), then COMMIT. Entry visible at COMMIT+1; command back-to-back capable at COMMIT+1.
  - SET_NUM: visible 1 cycle after accept.
  - CLEAR: TCAM_SUM cycles busy.
- Entries not targeted by a command hold their value. valid_num is unaffected by WRITE; software issues SET_NUM after loading.
- done and err never assert in the same cycle.

Test Plan:
- Reset -> line_message == {1'b1, all zeros}; valid_num == 0; cmd_ready == 1; busy == 0.
- WRITE addr = 2 with 6 beats 48'h1..48'h6, no stalls:
  - Entry 2 == {48'h6, 48'h5, 48'h4, 48'h3, 48'h2, 48'h1}; other entries remain 0.
  - done pulses at COMMIT; the entry first appears on line_message the cycle after COMMIT; busy is high for 7 cycles.
- WRITE addr = 1 with wr_valid deasserted for 3 cycles after beat 2:
  - line_message is unchanged until COMMIT.
  - The committed entry equals the concatenated beats; wr_ready drops after the last beat.
- SET_NUM cmd_num = 5 -> valid_num == 5 next cycle. SET_NUM cmd_num = 7 -> valid_num == 7 (TCAM_SUM-1); done pulses each time.
- WRITE addr = 7 with 6 beats -> all beats consumed, table unchanged, err pulses once, no done. Reserved op 11 -> err, state IDLE.
- Load entries 0..3 and set valid_num = 4, then CLEAR:
  - valid_num == 0 in the first cycle; all entries are 0 after 8 cycles; done, then cmd_ready == 1.
  - Separate run: rst asserted during beat 3 of a WRITE returns the block to the reset state with no entry committed.
